// File: rtl/id_issue_ctrl_if.sv
// IF/ID/EX handshake bundle for the decode-stage issue controller.
// slave is the controller's view, master the surrounding pipeline's view.
interface id_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic            flush;
    logic            ex_ready;
    logic            ex_is_load;
    logic [4:0]      ex_rd;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [1:0]      id_ext;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            lu_stall;
    logic [31:0]     stall_cnt;

    modport slave (
        input  if_valid, if_instr, if_pc, flush,
        input  ex_ready, ex_is_load, ex_rd,
        output if_ready, id_valid, id_instr, id_pc,
        output id_ext, id_rs1, id_rs2, id_rd,
        output lu_stall, stall_cnt
    );

    modport master (
        output if_valid, if_instr, if_pc, flush,
        output ex_ready, ex_is_load, ex_rd,
        input  if_ready, id_valid, id_instr, id_pc,
        input  id_ext, id_rs1, id_rs2, id_rd,
        input  lu_stall, stall_cnt
    );
endinterface

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: ID register, ext select, load-use bubble.
// Define ID_STALL_CNT_EN to build the saturating stall-cycle counter.
module id_issue_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h1eceb000)
) (
    input  logic          clk,
    input  logic          rst_n,
    id_issue_ctrl_if.slave bus
);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h00000013);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_LU_STALL
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic       held;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       use_rs1, use_rs2, use_rd;
    logic [1:0] ext;
    logic       haz;
    logic       adv;

    assign held   = (state_q != S_EMPTY);
    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign use_rd = !(opcode == OP_ST || opcode == OP_BR);

    // Operand usage and immediate-extender select from the held opcode.
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        ext     = 2'b00;
        case (opcode)
            OP_R:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_I:  begin
                use_rs1 = 1'b1;
                ext = (funct3 == 3'b001 || funct3 == 3'b101) ? 2'b00 : 2'b01;
            end
            OP_LD: begin use_rs1 = 1'b1; ext = 2'b01; end
            OP_ST: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_BR: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_JR: begin use_rs1 = 1'b1; ext = 2'b01; end
            OP_LUI, OP_AUI: ext = 2'b11;
            default: ;
        endcase
    end

    assign haz = held && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                 ((use_rs1 && instr_q[19:15] == bus.ex_rd) ||
                  (use_rs2 && instr_q[24:20] == bus.ex_rd));
    assign adv = !held || (bus.ex_ready && !haz);

    assign bus.if_ready = adv || bus.flush;
    assign bus.id_valid = held && !haz && !bus.flush;
    assign bus.lu_stall = held && haz && !bus.flush;
    assign bus.id_instr = instr_q;
    assign bus.id_pc    = pc_q;
    assign bus.id_ext   = ext;
    assign bus.id_rs1   = use_rs1 ? instr_q[19:15] : 5'd0;
    assign bus.id_rs2   = use_rs2 ? instr_q[24:20] : 5'd0;
    assign bus.id_rd    = use_rd  ? instr_q[11:7]  : 5'd0;

    // Next state: flush beats capture, capture beats drain, hazard holds.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (bus.flush) begin
            state_d = S_EMPTY;
        end else if (adv && bus.if_valid) begin
            state_d = S_FULL;
            instr_d = bus.if_instr;
            pc_d    = bus.if_pc;
        end else if (adv) begin
            state_d = S_EMPTY;
        end else if (haz) begin
            state_d = S_LU_STALL;
        end else begin
            state_d = S_FULL;
        end
    end

    // ID pipeline register and FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            instr_q <= NOP;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        cnt_inc;

    assign cnt_inc = held && !bus.flush && (haz || !bus.ex_ready);

    // Saturating count of cycles a held instruction could not issue.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && cnt_q != 32'hFFFFFFFF) cnt_d = cnt_q + 32'd1;
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 32'd0;
        else        cnt_q <= cnt_d;
    end

    assign bus.stall_cnt = cnt_q;
`else
    assign bus.stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Self-checking bench for id_issue_ctrl: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_id_issue_ctrl;
    localparam logic [31:0] RPC = 32'h1eceb000;
`ifdef ID_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_issue_ctrl_if #(.XLEN(32)) bus ();

    id_issue_ctrl #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // reference model state: is something held, and what
    bit          m_held;
    logic [31:0] m_instr, m_pc, m_cnt;

    function automatic logic [1:0] f_ext(logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        if (op == 7'h37 || op == 7'h17) return 2'b11;
        if (op == 7'h03 || op == 7'h67) return 2'b01;
        if (op == 7'h13 && i[14:12] != 3'd1 && i[14:12] != 3'd5) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit f_u1(logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    endfunction

    function automatic bit f_u2(logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    function automatic bit f_rd(logic [31:0] i);
        return !(i[6:0] inside {7'h23, 7'h63});
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic fl,
                         input logic rdy, input logic ld,
                         input logic [4:0] rd);
        bus.if_valid   = v;
        bus.if_instr   = ins;
        bus.if_pc      = pc;
        bus.flush      = fl;
        bus.ex_ready   = rdy;
        bus.ex_is_load = ld;
        bus.ex_rd      = rd;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 6;
        if (bus.id_valid !== 1'b0) begin failures++;
            $display("FAIL rst_id_valid got=%b exp=0", bus.id_valid); end
        if (bus.lu_stall !== 1'b0) begin failures++;
            $display("FAIL rst_lu_stall got=%b exp=0", bus.lu_stall); end
        if (bus.stall_cnt !== 32'd0) begin failures++;
            $display("FAIL rst_cnt got=%h exp=0", bus.stall_cnt); end
        if (bus.id_pc !== RPC) begin failures++;
            $display("FAIL rst_pc got=%h exp=%h", bus.id_pc, RPC); end
        if (bus.id_instr !== 32'h13) begin failures++;
            $display("FAIL rst_instr got=%h exp=13", bus.id_instr); end
        if (bus.if_ready !== 1'b1) begin failures++;
            $display("FAIL rst_if_ready got=%b exp=1", bus.if_ready); end
    endtask

    task automatic test_lui();
        do_reset();
        drive(1'b1, 32'h123450b7, 32'h1000, 1'b0, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
        checks += 5;
        if (bus.id_valid !== 1'b1) begin failures++;
            $display("FAIL lui_valid got=%b exp=1", bus.id_valid); end
        if (bus.id_ext !== 2'b11) begin failures++;
            $display("FAIL lui_ext got=%b exp=11", bus.id_ext); end
        if (bus.id_rd !== 5'd1) begin failures++;
            $display("FAIL lui_rd got=%0d exp=1", bus.id_rd); end
        if (bus.id_rs1 !== 5'd0) begin failures++;
            $display("FAIL lui_rs1 got=%0d exp=0", bus.id_rs1); end
        if (bus.id_pc !== 32'h1000) begin failures++;
            $display("FAIL lui_pc got=%h exp=1000", bus.id_pc); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 32'h00728333, 32'h2000, 1'b0, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5);
        checks += 3;
        if (bus.lu_stall !== 1'b1) begin failures++;
            $display("FAIL lu_stall got=%b exp=1", bus.lu_stall); end
        if (bus.id_valid !== 1'b0) begin failures++;
            $display("FAIL lu_valid got=%b exp=0", bus.id_valid); end
        if (bus.if_ready !== 1'b0) begin failures++;
            $display("FAIL lu_if_ready got=%b exp=0", bus.if_ready); end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
        checks += 4;
        if (bus.lu_stall !== 1'b0) begin failures++;
            $display("FAIL lu_after_stall got=%b exp=0", bus.lu_stall); end
        if (bus.id_valid !== 1'b1) begin failures++;
            $display("FAIL lu_after_valid got=%b exp=1", bus.id_valid); end
        if (bus.id_instr !== 32'h00728333) begin failures++;
            $display("FAIL lu_instr got=%h exp=00728333", bus.id_instr); end
        if (bus.stall_cnt !== (CNT_EN ? 32'd1 : 32'd0)) begin failures++;
            $display("FAIL lu_cnt got=%0d exp=%0d", bus.stall_cnt, CNT_EN); end
    endtask

    task automatic test_ext_decode();
        do_reset();
        drive(1'b1, 32'h00315093, 32'h10, 1'b0, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b1, 32'hfff10093, 32'h14, 1'b0, 1'b1, 1'b0, 5'd0);
        checks += 4;
        if (bus.id_ext !== 2'b00) begin failures++;
            $display("FAIL srli_ext got=%b exp=00", bus.id_ext); end
        if (bus.id_rs1 !== 5'd2) begin failures++;
            $display("FAIL srli_rs1 got=%0d exp=2", bus.id_rs1); end
        if (bus.id_rs2 !== 5'd0) begin failures++;
            $display("FAIL srli_rs2 got=%0d exp=0", bus.id_rs2); end
        if (bus.id_rd !== 5'd1) begin failures++;
            $display("FAIL srli_rd got=%0d exp=1", bus.id_rd); end
        @(negedge clk);
        drive(1'b1, 32'h00512223, 32'h18, 1'b0, 1'b1, 1'b0, 5'd0);
        checks += 2;
        if (bus.id_ext !== 2'b01) begin failures++;
            $display("FAIL addi_ext got=%b exp=01", bus.id_ext); end
        if (bus.id_rs1 !== 5'd2) begin failures++;
            $display("FAIL addi_rs1 got=%0d exp=2", bus.id_rs1); end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
        checks += 3;
        if (bus.id_ext !== 2'b00) begin failures++;
            $display("FAIL sw_ext got=%b exp=00", bus.id_ext); end
        if (bus.id_rd !== 5'd0) begin failures++;
            $display("FAIL sw_rd got=%0d exp=0", bus.id_rd); end
        if (bus.id_rs2 !== 5'd5) begin failures++;
            $display("FAIL sw_rs2 got=%0d exp=5", bus.id_rs2); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 32'hfff10093, 32'h3000, 1'b0, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b1, 32'h00728333, 32'h3004, 1'b1, 1'b1, 1'b0, 5'd0);
        checks += 2;
        if (bus.id_valid !== 1'b0) begin failures++;
            $display("FAIL fl_valid got=%b exp=0", bus.id_valid); end
        if (bus.if_ready !== 1'b1) begin failures++;
            $display("FAIL fl_if_ready got=%b exp=1", bus.if_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
            checks += 2;
            if (bus.id_valid !== 1'b0) begin failures++;
                $display("FAIL fl_post_valid[%0d] got=%b exp=0", k, bus.id_valid); end
            if (bus.id_pc === 32'h3004) begin failures++;
                $display("FAIL fl_wrong_path[%0d] got=%h exp!=3004", k, bus.id_pc); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 32'hfff10093, 32'h4000, 1'b0, 1'b1, 1'b0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h00728333, 32'h4004, 1'b0, 1'b0, 1'b0, 5'd0);
            checks += 3;
            if (bus.if_ready !== 1'b0) begin failures++;
                $display("FAIL bp_if_ready[%0d] got=%b exp=0", k, bus.if_ready); end
            if (bus.id_valid !== 1'b1) begin failures++;
                $display("FAIL bp_valid[%0d] got=%b exp=1", k, bus.id_valid); end
            if (bus.id_instr !== 32'hfff10093) begin failures++;
                $display("FAIL bp_instr[%0d] got=%h exp=fff10093", k, bus.id_instr); end
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
        checks += 2;
        if (bus.stall_cnt !== (CNT_EN ? 32'd3 : 32'd0)) begin failures++;
            $display("FAIL bp_cnt got=%0d exp=%0d", bus.stall_cnt, CNT_EN ? 3 : 0); end
        if (bus.id_instr !== 32'hfff10093) begin failures++;
            $display("FAIL bp_instr_end got=%h exp=fff10093", bus.id_instr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 32'h00728333, 32'h5000, 1'b0, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7);
        checks += 2;
        if (bus.lu_stall !== 1'b1) begin failures++;
            $display("FAIL ar_pre_stall got=%b exp=1", bus.lu_stall); end
        if (bus.stall_cnt !== (CNT_EN ? 32'd1 : 32'd0)) begin failures++;
            $display("FAIL ar_pre_cnt got=%0d exp=%0d", bus.stall_cnt, CNT_EN); end
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (bus.lu_stall !== 1'b0) begin failures++;
            $display("FAIL ar_stall got=%b exp=0", bus.lu_stall); end
        if (bus.id_valid !== 1'b0) begin failures++;
            $display("FAIL ar_valid got=%b exp=0", bus.id_valid); end
        if (bus.stall_cnt !== 32'd0) begin failures++;
            $display("FAIL ar_cnt got=%0d exp=0", bus.stall_cnt); end
        if (bus.id_pc !== RPC) begin failures++;
            $display("FAIL ar_pc got=%h exp=%h", bus.id_pc, RPC); end
        if (bus.id_instr !== 32'h13) begin failures++;
            $display("FAIL ar_instr got=%h exp=13", bus.id_instr); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h67, 7'h37, 7'h17, 7'h6f, 7'h73};
        logic [31:0] ins, pc;
        logic        v, fl, rdy, ld, haz, adv;
        logic [4:0]  erd;
        logic [4:0]  e1, e2, ed;
        do_reset();
        m_held = 1'b0; m_instr = 32'h13; m_pc = RPC; m_cnt = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            ins = {7'($urandom), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 3'($urandom),
                   5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]};
            pc  = $urandom;
            v   = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 9) < 4);
            erd = 5'($urandom_range(0, 3));
            drive(v, ins, pc, fl, rdy, ld, erd);
            haz = m_held && ld && erd != 0 &&
                  ((f_u1(m_instr) && m_instr[19:15] == erd) ||
                   (f_u2(m_instr) && m_instr[24:20] == erd));
            adv = !m_held || (rdy && !haz);
            e1 = f_u1(m_instr) ? m_instr[19:15] : 5'd0;
            e2 = f_u2(m_instr) ? m_instr[24:20] : 5'd0;
            ed = f_rd(m_instr) ? m_instr[11:7]  : 5'd0;
            checks += 10;
            if (bus.id_valid !== (m_held && !haz && !fl)) begin failures++;
                $display("FAIL rnd_valid@%0d got=%b exp=%b", n, bus.id_valid, m_held && !haz && !fl); end
            if (bus.lu_stall !== (m_held && haz && !fl)) begin failures++;
                $display("FAIL rnd_stall@%0d got=%b exp=%b", n, bus.lu_stall, m_held && haz && !fl); end
            if (bus.if_ready !== (adv || fl)) begin failures++;
                $display("FAIL rnd_if_ready@%0d got=%b exp=%b", n, bus.if_ready, adv || fl); end
            if (bus.id_instr !== m_instr) begin failures++;
                $display("FAIL rnd_instr@%0d got=%h exp=%h", n, bus.id_instr, m_instr); end
            if (bus.id_pc !== m_pc) begin failures++;
                $display("FAIL rnd_pc@%0d got=%h exp=%h", n, bus.id_pc, m_pc); end
            if (bus.id_ext !== f_ext(m_instr)) begin failures++;
                $display("FAIL rnd_ext@%0d got=%b exp=%b", n, bus.id_ext, f_ext(m_instr)); end
            if (bus.id_rs1 !== e1) begin failures++;
                $display("FAIL rnd_rs1@%0d got=%0d exp=%0d", n, bus.id_rs1, e1); end
            if (bus.id_rs2 !== e2) begin failures++;
                $display("FAIL rnd_rs2@%0d got=%0d exp=%0d", n, bus.id_rs2, e2); end
            if (bus.id_rd !== ed) begin failures++;
                $display("FAIL rnd_rd@%0d got=%0d exp=%0d", n, bus.id_rd, ed); end
            if (bus.stall_cnt !== m_cnt) begin failures++;
                $display("FAIL rnd_cnt@%0d got=%0d exp=%0d", n, bus.stall_cnt, m_cnt); end
            @(posedge clk);
            if (CNT_EN && m_held && !fl && (haz || !rdy) && m_cnt != 32'hFFFFFFFF)
                m_cnt = m_cnt + 1;
            if (fl) begin
                m_held = 1'b0;
            end else if (adv) begin
                m_held = v;
                if (v) begin m_instr = ins; m_pc = pc; end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0;
        bus.flush = 1'b0; bus.ex_ready = 1'b1;
        bus.ex_is_load = 1'b0; bus.ex_rd = '0;
        test_reset();
        test_lui();
        test_load_use();
        test_ext_decode();
        test_flush();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Decode-stage controller for the 5-stage RV32I pipeline, sitting between the IF/ID boundary and the EX stage.
- Holds the ID pipeline register (instr, pc) and generates the 2-bit `ext` select for the immediate extender.
- Extracts register indices and detects load-use hazards against EX, inserting one bubble per hazard.
- Sequences IF→ID→EX transfer with valid/ready handshakes and honours branch flushes from EX.

Parameters:
- XLEN, 32, width of pc and instruction words
- RESET_PC, 32'h1eceb000, value driven on id_pc while empty after reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  IF presents an instruction
- if_instr  in  XLEN  fetched instruction
- if_pc  in  XLEN  pc of fetched instruction
- if_ready  out  1  ID accepts if_instr this cycle
- flush  in  1  branch/jump redirect from EX; kill ID contents
- ex_ready  in  1  EX accepts an issue this cycle
- ex_is_load  in  1  instruction currently in EX is a load
- ex_rd  in  5  destination register of EX instruction
- id_valid  out  1  issue valid toward EX (bubble when 0)
- id_instr  out  XLEN  held instruction
- id_pc  out  XLEN  held pc
- id_ext  out  2  extender select: 11 U, 01 I, 00 other
- id_rs1, id_rs2, id_rd  out  5 each  register indices (0 when unused)
- lu_stall  out  1  load-use bubble being inserted this cycle
- stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state EMPTY, held instr=32'h00000013 (NOP), id_pc=RESET_PC, id_valid=0, lu_stall=0, stall_cnt=0. if_ready=1 combinationally once out of reset.
- FSM states:
  - EMPTY: no held instruction.
  - FULL: holding an instruction, issuing.
  - LU_STALL: holding an instruction behind a load.
- Hazard (combinational): haz = held && ex_is_load && ex_rd!=0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)).
- Source register usage:
  - uses_rs1 for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - uses_rs2 for 0110011, 0100011, 1100011.
- Register index outputs: id_rs1 / id_rs2 / id_rd are forced to 0 when the corresponding register is unused (stores and branches have no rd).
- id_ext decode:
  - 11 for 0110111 and 0010111.
  - 01 for 0000011, 1100111, and 0010011 with funct3 not in {001, 101}.
  - 00 for everything else, including shifts-immediate and stores.
- Issue outputs:
  - id_valid = held && !haz && !flush.
  - lu_stall = held && haz && !flush.
- Advance condition: adv = !held || (ex_ready && !haz). if_ready = adv || flush.
- Register update, evaluated in priority order each cycle:
  1. flush: held←0, state EMPTY. Any if_valid in the same cycle is discarded (wrong path).
  2. adv && if_valid: capture if_instr / if_pc, state FULL.
  3. adv && !if_valid: held←0, state EMPTY.
  4. haz: state LU_STALL, registers unchanged.
  5. Otherwise (ex_ready=0): registers unchanged, state FULL.
- LU_STALL exits to FULL or EMPTY by the rules above once EX no longer holds the matching load.
- Latency: one instruction accepted per cycle; zero-bubble back-to-back throughput; exactly one bubble per load-use pair when ex_ready=1.
- Reset asserted mid-stall or mid-flush returns all state to reset values immediately.

Optional Feature:
- Macro: ID_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on every cycle where held && !flush && (haz || !ex_ready). It saturates at 32'hFFFFFFFF and never wraps; it clears only on reset.
- Undefined: stall_cnt is tied to 32'h0 and no counter flops are present.

Test Plan:
- Reset then if_valid with instr 32'h123450b7 (LUI) → next cycle id_valid=1, id_ext=11, id_rd=1, id_rs1=0.
- EX load with ex_rd=5; ID holds add x6,x5,x7 (32'h00728333) → lu_stall=1, id_valid=0, if_ready=0 for 1 cycle; then id_valid=1 once ex_is_load drops.
- ID holds srli x1,x2,3 (32'h00315093) → id_ext=00, id_rs1=2, id_rs2=0. ID holds addi x1,x2,-1 → id_ext=01.
- flush asserted together with if_valid=1 → next cycle held=0, id_valid=0, and the flushed instruction is never issued.
- ex_ready=0 for 3 cycles while FULL → id_instr stable, if_ready=0; with ID_STALL_CNT_EN defined, stall_cnt=3.
- rst_n pulsed low during LU_STALL → outputs return to reset values asynchronously; stall_cnt=0.
